// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: the symbol width and the four control-period codes.
package tmds_pkg;

  localparam int TMDS_WORD_W = 10;

  localparam logic [TMDS_WORD_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [TMDS_WORD_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [TMDS_WORD_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [TMDS_WORD_W-1:0] CTRL_11 = 10'b1010101011;

endpackage

// File: rtl/tmds_gearbox_lane.sv
// One TMDS lane of the gearbox: 10-bit shift register emitting two bits per cycle, LSB first.
module tmds_gearbox_lane
  import tmds_pkg::*;
#(
  parameter logic [TMDS_WORD_W-1:0] IDLE_WORD = CTRL_00
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   shift_en,
  input  logic                   load_en,
  input  logic [TMDS_WORD_W-1:0] word,
  output logic                   d0,
  output logic                   d1
);

  logic [TMDS_WORD_W-1:0] sh;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh <= IDLE_WORD;
    end else if (load_en) begin
      sh <= word;
    end else if (shift_en) begin
      sh <= {2'b00, sh[TMDS_WORD_W-1:2]};
    end
  end

  // Output pair comes straight from the register, so the DDR cells see no input-to-output path.
  assign d0 = sh[0];
  assign d1 = sh[1];

endmodule

// File: rtl/tmds_gearbox.sv
// 10:2 TMDS gearbox on the 5x serial clock: one word set per 5 cycles in, a DDR bit pair per lane per cycle out.
// Defining TMDS_GEARBOX_CALIB_EN enables the calib rising-edge word-boundary slip; otherwise calib is ignored.
module tmds_gearbox
  import tmds_pkg::*;
#(
  parameter int                     CHANNELS  = 3,
  parameter logic [TMDS_WORD_W-1:0] IDLE_WORD = CTRL_00
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [CHANNELS*TMDS_WORD_W-1:0] in_data,
  input  logic                            calib,
  output logic [CHANNELS-1:0]             out_d0,
  output logic [CHANNELS-1:0]             out_d1,
  output logic                            load,
  output logic                            underrun
);

  localparam int DW = CHANNELS * TMDS_WORD_W;

  logic [2:0]    p;
  logic [DW-1:0] hold;
  logic [DW-1:0] next_word;
  logic          hold_full;
  logic          underrun_q;
  logic          slip;
  logic          advance;
  logic          word_end;
  logic          accept;
  logic          bypass;

`ifdef TMDS_GEARBOX_CALIB_EN
  logic calib_q;
  logic slip_q;

  // A slip freezes phase and lanes for one cycle so the current pair repeats.
  assign slip = calib && !calib_q && !slip_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      calib_q <= 1'b0;
      slip_q  <= 1'b0;
    end else begin
      calib_q <= calib;
      slip_q  <= slip;
    end
  end
`else
  logic calib_unused;
  assign calib_unused = calib;
  assign slip         = 1'b0;
`endif

  assign advance  = !slip;
  assign word_end = (p == 3'd4) && advance;
  assign in_ready = !reset && (!hold_full || word_end);
  assign accept   = in_valid && in_ready;
  assign bypass   = word_end && !hold_full && accept;
  assign load     = (p == 3'd0);
  assign underrun = underrun_q;

  // The held word is older than anything on in_data, so it always wins the load.
  always_comb begin
    next_word = {CHANNELS{IDLE_WORD}};
    if (hold_full) begin
      next_word = hold;
    end else if (bypass) begin
      next_word = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p          <= 3'd0;
      hold       <= '0;
      hold_full  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (advance) begin
        p <= (p == 3'd4) ? 3'd0 : p + 3'd1;
      end
      if (word_end && !hold_full && !bypass) begin
        underrun_q <= 1'b1;
      end
      if (accept && !bypass) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end else if (word_end && hold_full) begin
        hold_full <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    tmds_gearbox_lane #(
      .IDLE_WORD(IDLE_WORD)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .shift_en(advance && (p != 3'd4)),
      .load_en (word_end),
      .word    (next_word[g*TMDS_WORD_W +: TMDS_WORD_W]),
      .d0      (out_d0[g]),
      .d1      (out_d1[g])
    );
  end

endmodule

// File: tb/tb_tmds_gearbox.sv
// Bench for tmds_gearbox: directed scenarios plus random traffic against a word-slot/FIFO reference model.
module tb_tmds_gearbox;
  import tmds_pkg::*;

  localparam int         C    = 3;
  localparam int         DW   = C * 10;
  localparam logic [9:0] IDLE = CTRL_00;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          in_valid = 1'b0;
  logic          calib    = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          in_ready;
  logic          load;
  logic          underrun;
  logic [C-1:0]  out_d0;
  logic [C-1:0]  out_d1;

  int total = 0;
  int bad   = 0;

  // Reference model: current word per lane, position in its slot, FIFO of accepted-but-unsent words.
  logic [9:0]    cur [C];
  logic [DW-1:0] pend[$];
  int            pos;
  logic          und_m;
  logic          calib_prev;
  logic          slip_prev;
  logic          acc;
  int            k;

  always #5 clk = ~clk;

  tmds_gearbox #(
    .CHANNELS (C),
    .IDLE_WORD(IDLE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .calib   (calib),
    .out_d0  (out_d0),
    .out_d1  (out_d1),
    .load    (load),
    .underrun(underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int v);
    logic [DW-1:0] r;
    for (int n = 0; n < C; n++) r[10*n +: 10] = 10'(v + 16 * n);
    return r;
  endfunction

  task automatic model_reset();
    pos = 0;
    for (int n = 0; n < C; n++) cur[n] = IDLE;
    pend.delete();
    und_m      = 1'b0;
    calib_prev = 1'b0;
    slip_prev  = 1'b0;
  endtask

  // Entered at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle();
    logic [C-1:0]  e0;
    logic [C-1:0]  e1;
    logic          slip;
    logic          rdy;
    logic [DW-1:0] w;
    #1;
`ifdef TMDS_GEARBOX_CALIB_EN
    slip = calib && !calib_prev && !slip_prev;
`else
    slip = 1'b0;
`endif
    rdy = (pend.size() == 0) || (pos == 4 && !slip);
    for (int n = 0; n < C; n++) begin
      e0[n] = cur[n][2*pos];
      e1[n] = cur[n][2*pos+1];
    end
    chk("out_d0", out_d0, e0);
    chk("out_d1", out_d1, e1);
    chk("load", load, pos == 0);
    chk("underrun", underrun, und_m);
    chk("in_ready", in_ready, rdy);
    acc = in_valid && rdy;
    if (acc) pend.push_back(in_data);
    if (!slip) begin
      if (pos == 4) begin
        if (pend.size() > 0) begin
          w = pend.pop_front();
          for (int n = 0; n < C; n++) cur[n] = w[10*n +: 10];
        end else begin
          for (int n = 0; n < C; n++) cur[n] = IDLE;
          und_m = 1'b1;
        end
        pos = 0;
      end else begin
        pos++;
      end
    end
    calib_prev = calib;
    slip_prev  = slip;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    calib    = 1'b0;
    #1;
    chk("rst_in_ready_async", in_ready, 0);
    @(posedge clk);
    #1;
    chk("rst_d0", out_d0, {C{IDLE[0]}});
    chk("rst_d1", out_d1, {C{IDLE[1]}});
    chk("rst_load", load, 1);
    chk("rst_underrun", underrun, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;

    // Idle pattern after reset, underrun sets at the first empty slot.
    do_reset();
    repeat (12) cycle();

    // Bypass accept at the first word boundary.
    do_reset();
    for (int i = 0; i < 6 && pos != 4; i++) cycle();
    in_valid = 1'b1;
    in_data  = {20'($urandom()), 10'h3A5};
    cycle();
    in_valid = 1'b0;
    repeat (6) cycle();

    // Back-to-back streaming of incrementing words.
    do_reset();
    k        = 1;
    in_data  = mk(k);
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (acc) begin
        k++;
        in_data = mk(k);
      end
    end

    // Starvation then recovery.
    in_valid = 1'b0;
    repeat (12) cycle();
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (acc) begin
        k++;
        in_data = mk(k);
      end
    end

    // Calib pulse at phase 2 (slip only when the feature is built in).
    for (int i = 0; i < 6 && pos != 2; i++) cycle();
    calib = 1'b1;
    cycle();
    calib = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (acc) begin
        k++;
        in_data = mk(k);
      end
    end

    // Reset in the middle of a word while hold is occupied.
    for (int i = 0; i < 12 && !(pos == 3 && pend.size() == 1); i++) begin
      cycle();
      if (acc) begin
        k++;
        in_data = mk(k);
      end
    end
    do_reset();
    repeat (6) cycle();

    // Random traffic, jitter and calib pulses.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 99) < 65);
      in_data  = DW'($urandom());
      calib    = ($urandom_range(0, 19) == 0);
      cycle();
    end
    calib = 1'b0;
    in_valid = 1'b0;
    repeat (10) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
